// File: rtl/fault_aggregator_pkg.sv
// Shared types and constants for the fault aggregator.
// Optional feature macro: FAULT_COUNT_EN (per-channel fault edge counters).
package fault_aggregator_pkg;

  localparam int MAX_CHANNELS = 16;

  typedef logic [2:0] fault_state_t;

  localparam fault_state_t S_IDLE    = 3'd0;
  localparam fault_state_t S_SETTLE  = 3'd1;
  localparam fault_state_t S_CHECK   = 3'd2;
  localparam fault_state_t S_RELEASE = 3'd3;
  localparam fault_state_t S_WAIT    = 3'd4;
  localparam fault_state_t S_DRIVE   = 3'd5;
  localparam fault_state_t S_TIMEOUT = 3'd6;

  // One timer serves both the settle delay and the timeout, so size it for the larger.
  function automatic int timer_width(input int settle_cycles, input int timeout_cycles);
    int m;
    m = (settle_cycles > timeout_cycles) ? settle_cycles : timeout_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fault_aggregator_if.sv
// Bus-side and nFault-side signals of the fault aggregator.
// Optional feature macro: FAULT_COUNT_EN adds fault_count and the CNT_WIDTH parameter.
interface fault_aggregator_if #(
  parameter int NUM_CHANNELS = 4
`ifdef FAULT_COUNT_EN
  , parameter int CNT_WIDTH  = 8
`endif
);
  logic                    register_address_valid;
  logic [NUM_CHANNELS-1:0] subsystem_enable;
  logic [NUM_CHANNELS-1:0] fault_in;
  logic [NUM_CHANNELS-1:0] fault_clear;
  logic                    set_nFault_z;
  logic                    set_nFault_value;
  logic                    nFault_level;
  logic [NUM_CHANNELS-1:0] fault_sticky;
  logic                    timeout_error;
`ifdef FAULT_COUNT_EN
  logic [NUM_CHANNELS*CNT_WIDTH-1:0] fault_count;

  modport master (
    output register_address_valid, subsystem_enable, fault_in, fault_clear,
    input  set_nFault_z, set_nFault_value, nFault_level, fault_sticky, timeout_error,
           fault_count
  );
  modport slave (
    input  register_address_valid, subsystem_enable, fault_in, fault_clear,
    output set_nFault_z, set_nFault_value, nFault_level, fault_sticky, timeout_error,
           fault_count
  );
`else
  modport master (
    output register_address_valid, subsystem_enable, fault_in, fault_clear,
    input  set_nFault_z, set_nFault_value, nFault_level, fault_sticky, timeout_error
  );
  modport slave (
    input  register_address_valid, subsystem_enable, fault_in, fault_clear,
    output set_nFault_z, set_nFault_value, nFault_level, fault_sticky, timeout_error
  );
`endif
endinterface

// File: rtl/fault_aggregator_channel.sv
// One monitored channel: sticky fault latch and, with FAULT_COUNT_EN, a saturating
// counter of fault_i rising edges.
module fault_channel
`ifdef FAULT_COUNT_EN
  #(parameter int CNT_WIDTH = 8)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic fault_i,
  input  logic clear_i,
`ifdef FAULT_COUNT_EN
  output logic [CNT_WIDTH-1:0] count_o,
`endif
  output logic sticky_o
);

  logic sticky_q, sticky_d;

  // A fault arriving in the same cycle as a clear must not be lost, so set wins.
  assign sticky_d = fault_i | (sticky_q & ~clear_i);

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (!reset) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;

`ifdef FAULT_COUNT_EN
  logic                 fault_prev_q;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Count rising edges, saturating at all-ones; clear takes priority.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (fault_i && !fault_prev_q && !(&count_q))
      count_d = count_q + 1'b1;
  end

  // Edge history and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_prev_q <= 1'b0;
      count_q      <= '0;
    end else begin
      fault_prev_q <= fault_i;
      count_q      <= count_d;
    end
  end

  assign count_o = count_q;
`endif

endmodule

// File: rtl/fault_aggregator.sv
// Multi-channel nFault controller: FSM, shared settle/timeout timer, select register
// and one fault_channel per monitored subsystem.
// Optional feature macro: FAULT_COUNT_EN (per-channel fault edge counters on fault_count).
//
// state     | meaning
// S_IDLE    | no transaction; nFault untouched
// S_SETTLE  | waiting for subsystem_enable to settle after address-valid
// S_CHECK   | capture subsystem_enable into sel
// S_RELEASE | no channel addressed; pulse set_nFault_z
// S_WAIT    | addressed; waiting for end of transaction or timeout
// S_DRIVE   | pulse set_nFault_value with selected fault status
// S_TIMEOUT | transaction overran; report once, hold level low until rav drops
module fault_aggregator
  import fault_aggregator_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input logic               clk,
  input logic               reset,
  fault_aggregator_if.slave bus
);

  localparam int TW = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS || SETTLE_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("fault_aggregator: parameter out of range");
  end

  fault_state_t            state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [NUM_CHANNELS-1:0] sel_q, sel_d;
  logic                    to_entry_q, to_entry_d;
  logic [NUM_CHANNELS-1:0] sticky;

  // Next-state, timer and select decode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sel_d      = sel_q;
    to_entry_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.register_address_valid) begin
          state_d = S_SETTLE;
          timer_d = '0;
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_LAST) state_d = S_CHECK;
        else                        timer_d = timer_q + 1'b1;
      end
      S_CHECK: begin
        sel_d = bus.subsystem_enable;
        if (bus.subsystem_enable == '0) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      S_WAIT: begin
        if (!bus.register_address_valid) begin
          state_d = S_DRIVE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d    = S_TIMEOUT;
          to_entry_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DRIVE: state_d = S_IDLE;
      S_TIMEOUT: begin
        if (!bus.register_address_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM registers; reset aborts any transaction without pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      sel_q      <= '0;
      to_entry_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      to_entry_q <= to_entry_d;
    end
  end

  // Moore outputs; the timeout report fires only on the first S_TIMEOUT cycle.
  assign bus.set_nFault_z     = (state_q == S_RELEASE);
  assign bus.set_nFault_value = (state_q == S_DRIVE) || ((state_q == S_TIMEOUT) && to_entry_q);
  assign bus.timeout_error    = (state_q == S_TIMEOUT) && to_entry_q;
  assign bus.nFault_level     = (state_q == S_DRIVE)   ? ~|(sticky & sel_q) :
                                (state_q == S_TIMEOUT) ? 1'b0 : 1'b1;
  assign bus.fault_sticky     = sticky;

`ifdef FAULT_COUNT_EN
  logic [NUM_CHANNELS*CNT_WIDTH-1:0] count;
  assign bus.fault_count = count;
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
`ifdef FAULT_COUNT_EN
    fault_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .fault_i  (bus.fault_in[i]),
      .clear_i  (bus.fault_clear[i]),
      .count_o  (count[i*CNT_WIDTH +: CNT_WIDTH]),
      .sticky_o (sticky[i])
    );
`else
    fault_channel u_ch (
      .clk      (clk),
      .reset    (reset),
      .fault_i  (bus.fault_in[i]),
      .clear_i  (bus.fault_clear[i]),
      .sticky_o (sticky[i])
    );
`endif
  end

endmodule

// File: tb/tb_fault_aggregator.sv
// Self-checking bench for fault_aggregator (table of transactions plus corner sequences).
module tb_fault_aggregator;

  localparam int N       = 4;
  localparam int SETTLE  = 1;
  localparam int TIMEOUT = 8;
  localparam int CW      = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

`ifdef FAULT_COUNT_EN
  fault_aggregator_if #(.NUM_CHANNELS(N), .CNT_WIDTH(CW)) bus ();
`else
  fault_aggregator_if #(.NUM_CHANNELS(N)) bus ();
`endif

  fault_aggregator #(
    .NUM_CHANNELS(N), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic z;
    logic val;
    logic tmo;
    logic lvl;
  } pulse_t;

  typedef struct {
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] en;
    int           rav_len;
    logic         exp_z;
    logic         exp_lvl;
    logic [N-1:0] exp_sticky;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     pulse_cnt = 0;
  int     to_cnt = 0;
  logic   mon_en = 1'b0;
  pulse_t exp_q[$];
  vec_t   vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every output pulse must match the next expected pulse.
  always @(negedge clk) begin
    if (mon_en && (bus.set_nFault_z || bus.set_nFault_value || bus.timeout_error)) begin
      pulse_t got;
      pulse_t want;
      got = '{z: bus.set_nFault_z, val: bus.set_nFault_value,
              tmo: bus.timeout_error, lvl: bus.nFault_level};
      pulse_cnt++;
      if (bus.timeout_error) to_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(got), 32'(0));
      end else begin
        want = exp_q.pop_front();
        check("pulse", 32'(got), 32'(want));
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 15) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_faults(input logic [N-1:0] set, input logic [N-1:0] clr);
    @(negedge clk);
    bus.fault_in    = set;
    bus.fault_clear = clr;
    @(negedge clk);
    bus.fault_in    = '0;
    bus.fault_clear = '0;
  endtask

  task automatic txn(input logic [N-1:0] en, input int rav_len);
    bus.register_address_valid = 1'b1;
    bus.subsystem_enable       = en;
    repeat (rav_len) @(negedge clk);
    bus.register_address_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    //          set      clr      en       len z  lvl sticky
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 3, 1, 1, 4'b0000};
    vecs[1] = '{4'b0100, 4'b0000, 4'b0100, 4, 0, 0, 4'b0100};
    vecs[2] = '{4'b0000, 4'b0100, 4'b0001, 5, 0, 1, 4'b0000};
    vecs[3] = '{4'b0100, 4'b0100, 4'b0100, 3, 0, 0, 4'b0100};
    vecs[4] = '{4'b0001, 4'b0000, 4'b0001, 6, 0, 0, 4'b0101};
    vecs[5] = '{4'b1010, 4'b0101, 4'b0011, 4, 0, 0, 4'b1010};
    vecs[6] = '{4'b0000, 4'b0010, 4'b0011, 3, 0, 1, 4'b1000};
    vecs[7] = '{4'b0000, 4'b0000, 4'b1111, 5, 0, 0, 4'b1000};
    vecs[8] = '{4'b0000, 4'b1111, 4'b1111, 4, 0, 1, 4'b0000};

    bus.register_address_valid = 1'b0;
    bus.subsystem_enable       = '0;
    bus.fault_in               = '0;
    bus.fault_clear            = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_z",      32'(bus.set_nFault_z),     32'(0));
    check("rst_value",  32'(bus.set_nFault_value), 32'(0));
    check("rst_level",  32'(bus.nFault_level),     32'(1));
    check("rst_sticky", 32'(bus.fault_sticky),     32'(0));
    check("rst_tmo",    32'(bus.timeout_error),    32'(0));
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      pulse_faults(vecs[i].set, vecs[i].clr);
      check($sformatf("sticky_v%0d", i), 32'(bus.fault_sticky), 32'(vecs[i].exp_sticky));
      if (vecs[i].exp_z) exp_q.push_back('{z: 1'b1, val: 1'b0, tmo: 1'b0, lvl: 1'b1});
      else               exp_q.push_back('{z: 1'b0, val: 1'b1, tmo: 1'b0, lvl: vecs[i].exp_lvl});
      txn(vecs[i].en, vecs[i].rav_len);
      drain($sformatf("drain_v%0d", i));
      bus.subsystem_enable = '0;
    end

    // Timeout: rav held far past TIMEOUT_CYCLES gives exactly one report.
    exp_q.push_back('{z: 1'b0, val: 1'b1, tmo: 1'b1, lvl: 1'b0});
    txn(4'b0001, 20);
    check("to_level_held", 32'(bus.nFault_level), 32'(0));
    @(negedge clk);
    check("to_level_released", 32'(bus.nFault_level), 32'(1));
    drain("drain_timeout");
    check("to_count", 32'(to_cnt), 32'(1));

    // Reset in S_WAIT: abort silently and clear sticky flags.
    pulse_faults(4'b1000, 4'b0000);
    check("sticky_pre_rst", 32'(bus.fault_sticky), 32'(4'b1000));
    p0 = pulse_cnt;
    bus.register_address_valid = 1'b1;
    bus.subsystem_enable       = 4'b1000;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    bus.register_address_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_sticky", 32'(bus.fault_sticky), 32'(0));
    check("rst_mid_level",  32'(bus.nFault_level), 32'(1));
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_no_pulse", 32'(pulse_cnt - p0), 32'(0));
    exp_q.push_back('{z: 1'b0, val: 1'b1, tmo: 1'b0, lvl: 1'b1});
    txn(4'b1000, 3);
    drain("drain_post_rst");
    bus.subsystem_enable = '0;

`ifdef FAULT_COUNT_EN
    pulse_faults(4'b0000, 4'b1111);
    for (int k = 0; k < 2; k++) pulse_faults(4'b0010, 4'b0000);
    check("cnt_ch1_two", 32'(bus.fault_count[1*CW +: CW]), 32'(2));
    for (int k = 0; k < 3; k++) pulse_faults(4'b0010, 4'b0000);
    check("cnt_ch1_sat", 32'(bus.fault_count[1*CW +: CW]), 32'(3));
    check("cnt_ch0_idle", 32'(bus.fault_count[0 +: CW]), 32'(0));
    pulse_faults(4'b0010, 4'b0010);
    check("cnt_ch1_clear", 32'(bus.fault_count[1*CW +: CW]), 32'(0));
`endif

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
